// File: rtl/cpu_pkg.sv
// Shared encodings for the decode stage: opcodes, R-type functs, ALU controls
// and the control bundle carried into the ID/EX register.
package cpu_pkg;

    localparam int BUS_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one write port,
// r0 hardwired to zero, and a write-through bypass for same-cycle reads.
module reg_file
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH  = cpu_pkg::BUS_WIDTH,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [BUS_WIDTH-1:0]  rdata1_o,
    output logic [BUS_WIDTH-1:0]  rdata2_o,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [BUS_WIDTH-1:0]  wdata_i
);

    logic [BUS_WIDTH-1:0] regs_q [NUM_REGS];
    logic                 wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [BUS_WIDTH-1:0] rd_port(input logic [REG_ADDR_W-1:0] addr,
                                                     input logic [BUS_WIDTH-1:0]  stored);
        if (addr == '0) begin
            return '0;
        end else if (wr_en && (waddr_i == addr)) begin
            return wdata_i;
        end else begin
            return stored;
        end
    endfunction

    assign rdata1_o = rd_port(raddr1_i, regs_q[raddr1_i]);
    assign rdata2_o = rd_port(raddr2_i, regs_q[raddr2_i]);

endmodule

// File: rtl/decode_stage.sv
// ID stage: field extraction, control decode, load-use stall detection and
// the ID/EX pipeline register feeding execute.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH  = cpu_pkg::BUS_WIDTH,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [BUS_WIDTH-1:0]  InstrD,
    input  logic [BUS_WIDTH-1:0]  PCD,
    input  logic                  FlushD,
    input  logic                  MemReadE_in,
    input  logic [REG_ADDR_W-1:0] RtE_in,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic [BUS_WIDTH-1:0]  ResultW,
    output logic                  StallF,
    output logic [BUS_WIDTH-1:0]  RD1E,
    output logic [BUS_WIDTH-1:0]  RD2E,
    output logic [BUS_WIDTH-1:0]  ImmE,
    output logic [REG_ADDR_W-1:0] RsE,
    output logic [REG_ADDR_W-1:0] RtE,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic [BUS_WIDTH-1:0]  PCE,
    output logic                  RegWriteE,
    output logic                  MemtoRegE,
    output logic                  MemWriteE,
    output logic                  MemReadE,
    output logic                  ALUSrcE,
    output logic                  RegDstE,
    output logic                  BranchE,
    output logic [2:0]            ALUCtrlE,
    output logic                  IllegalE,
    output logic                  ValidE
);

    logic [5:0]            op;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [BUS_WIDTH-1:0]  imm_ext;
    logic [BUS_WIDTH-1:0]  rd1;
    logic [BUS_WIDTH-1:0]  rd2;
    logic                  stall;
    logic                  bubble;
    ctrl_t                 ctrl_d, ctrl_q;
    logic                  valid_q;
    logic [BUS_WIDTH-1:0]  rd1_q, rd2_q, imm_q, pc_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;

    assign op      = InstrD[31:26];
    assign rs      = InstrD[25:21];
    assign rt      = InstrD[20:16];
    assign rd      = InstrD[15:11];
    assign funct   = InstrD[5:0];
    assign imm_ext = {{(BUS_WIDTH-16){InstrD[15]}}, InstrD[15:0]};

    reg_file #(
        .BUS_WIDTH (BUS_WIDTH),
        .REG_ADDR_W(REG_ADDR_W),
        .NUM_REGS  (NUM_REGS)
    ) u_reg_file (
        .clk     (CLK),
        .rst_n_i (RST_N),
        .raddr1_i(rs),
        .raddr2_i(rt),
        .rdata1_o(rd1),
        .rdata2_o(rd2),
        .we_i    (RegWriteW),
        .waddr_i (WriteRegW),
        .wdata_i (ResultW)
    );

    // Flush kills the instruction outright, so it suppresses the stall.
    assign stall  = MemReadE_in && (RtE_in != '0) && ((RtE_in == rs) || (RtE_in == rt)) && !FlushD;
    assign StallF = stall && RST_N;
    assign bubble = stall || FlushD;

    always_comb begin
        ctrl_d = '0;
        if (InstrD != '0) begin
            unique case (op)
                OP_RTYPE: begin
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.reg_dst   = 1'b1;
                    unique case (funct)
                        FN_ADD:  ctrl_d.alu_ctrl = ALU_ADD;
                        FN_SUB:  ctrl_d.alu_ctrl = ALU_SUB;
                        FN_AND:  ctrl_d.alu_ctrl = ALU_AND;
                        FN_OR:   ctrl_d.alu_ctrl = ALU_OR;
                        FN_SLT:  ctrl_d.alu_ctrl = ALU_SLT;
                        default: begin
                            ctrl_d         = '0;
                            ctrl_d.illegal = 1'b1;
                        end
                    endcase
                end
                OP_ADDI: begin
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.alu_ctrl  = ALU_ADD;
                end
                OP_LW: begin
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.alu_src    = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                    ctrl_d.mem_read   = 1'b1;
                    ctrl_d.alu_ctrl   = ALU_ADD;
                end
                OP_SW: begin
                    ctrl_d.mem_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.alu_ctrl  = ALU_ADD;
                end
                OP_BEQ: begin
                    ctrl_d.branch   = 1'b1;
                    ctrl_d.alu_ctrl = ALU_SUB;
                end
                default: ctrl_d.illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            ctrl_q  <= bubble ? '0 : ctrl_d;
            valid_q <= !bubble;
            rd1_q   <= rd1;
            rd2_q   <= rd2;
            imm_q   <= imm_ext;
            pc_q    <= PCD;
            rs_q    <= rs;
            rt_q    <= rt;
            rd_q    <= rd;
        end
    end

    assign RD1E      = rd1_q;
    assign RD2E      = rd2_q;
    assign ImmE      = imm_q;
    assign PCE       = pc_q;
    assign RsE       = rs_q;
    assign RtE       = rt_q;
    assign RdE       = rd_q;
    assign RegWriteE = ctrl_q.reg_write;
    assign MemtoRegE = ctrl_q.mem_to_reg;
    assign MemWriteE = ctrl_q.mem_write;
    assign MemReadE  = ctrl_q.mem_read;
    assign ALUSrcE   = ctrl_q.alu_src;
    assign RegDstE   = ctrl_q.reg_dst;
    assign BranchE   = ctrl_q.branch;
    assign ALUCtrlE  = ctrl_q.alu_ctrl;
    assign IllegalE  = ctrl_q.illegal;
    assign ValidE    = valid_q;

endmodule
